// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg: shared DES key-schedule constants and helpers.
//   KEY_W / HALF_W / SUBKEY_W : widths of the key, each C/D half and a subkey.
//   PC1 / PC2                 : permuted-choice tables, DES bit numbering (1 = MSB).
//   SHIFTS                    : encrypt-order left-rotate amount per round.
//   pc1_permute               : 64-bit key -> 56-bit {C0, D0}.
//   rotl28 / rotr28           : rotate a 28-bit half by 0..2 positions.
//   shift_amt                 : rotate amount applied to reach a given issue index.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int unsigned SHIFTS [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // DES bit n lives at key[64-n]; parity bits (8, 16, ..) are never selected.
    function automatic logic [55:0] pc1_permute(logic [KEY_W-1:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[64-PC1[i]];
        end
        return cd;
    endfunction

    function automatic logic [HALF_W-1:0] rotl28(logic [HALF_W-1:0] x, logic [1:0] n);
        logic [HALF_W-1:0] r;
        case (n)
            2'd1:    r = {x[26:0], x[27]};
            2'd2:    r = {x[25:0], x[27:26]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(logic [HALF_W-1:0] x, logic [1:0] n);
        logic [HALF_W-1:0] r;
        case (n)
            2'd1:    r = {x[0], x[27:1]};
            2'd2:    r = {x[1:0], x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    // Decrypt walks the encrypt schedule backwards: index i undoes encrypt shift 16-i.
    function automatic logic [1:0] shift_amt(logic dec, logic [3:0] idx);
        logic [1:0] a;
        if (!dec) begin
            a = 2'(SHIFTS[idx]);
        end else if (idx == 4'd0) begin
            a = 2'd0;
        end else begin
            a = 2'(SHIFTS[4'(5'd16 - 5'(idx))]);
        end
        return a;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// -----------------------------------------------------------------------------
// des_key_schedule_if: request/subkey handshake bundle of the key scheduler.
//   start, decrypt, key : schedule request (driven by master)
//   subkey_ready        : consumer accept (driven by master)
//   subkey, subkey_valid, round_idx, busy, done : scheduler outputs (slave)
// -----------------------------------------------------------------------------
interface des_key_schedule_if;

    logic                          start;
    logic                          decrypt;
    logic [des_pkg::KEY_W-1:0]     key;
    logic [des_pkg::SUBKEY_W-1:0]  subkey;
    logic                          subkey_valid;
    logic                          subkey_ready;
    logic [3:0]                    round_idx;
    logic                          busy;
    logic                          done;

    modport master (
        output start, decrypt, key, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  start, decrypt, key, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );

endinterface

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2: combinational DES permuted choice 2.
//   cd_i     : 56-bit {C, D}, bit 55 = C bit 1
//   subkey_o : 48-bit round subkey, bit 47 = DES bit 1
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0]         cd_i,
    output logic [SUBKEY_W-1:0] subkey_o
);

    always_comb begin
        subkey_o = '0;
        for (int i = 0; i < 48; i++) begin
            subkey_o[47-i] = cd_i[56-PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule: sequential DES subkey generator, one subkey per handshake.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of des_key_schedule_if (start/decrypt/key in,
//                subkey/subkey_valid/round_idx/busy/done out, subkey_ready in)
// Encrypt issues K1..K16, decrypt issues K16..K1 by rotating C/D rightwards.
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input logic              clk,
    input logic              rst_n,
    des_key_schedule_if.slave bus
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StIssue = 1'b1;
    localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS - 1);

    logic [0:0]          state_q, state_d;
    logic [HALF_W-1:0]   c_half_q, c_half_d;
    logic [HALF_W-1:0]   d_half_q, d_half_d;
    logic [SUBKEY_W-1:0] subkey_q, subkey_d;
    logic                valid_q, valid_d;
    logic [3:0]          idx_q, idx_d;
    logic                done_q, done_d;
    logic                dec_q, dec_d;

    logic [55:0]         cd0;
    logic [1:0]          amt;
    logic                accept;
    logic                load_subkey;
    logic [SUBKEY_W-1:0] pc2_out;

    assign accept = valid_q && bus.subkey_ready;

    always_comb begin
        state_d     = state_q;
        c_half_d    = c_half_q;
        d_half_d    = d_half_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        dec_d       = dec_q;
        done_d      = 1'b0;
        load_subkey = 1'b0;
        cd0         = pc1_permute(bus.key);
        amt         = shift_amt(dec_q, idx_q + 4'd1);

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Decrypt starts unrotated: 28 total shifts bring C/D back to K16.
                    if (bus.decrypt) begin
                        c_half_d = cd0[55:28];
                        d_half_d = cd0[27:0];
                    end else begin
                        c_half_d = rotl28(cd0[55:28], 2'd1);
                        d_half_d = rotl28(cd0[27:0], 2'd1);
                    end
                    dec_d       = bus.decrypt;
                    valid_d     = 1'b1;
                    idx_d       = 4'd0;
                    load_subkey = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    if (idx_q == LastIdx) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        if (dec_q) begin
                            c_half_d = rotr28(c_half_q, amt);
                            d_half_d = rotr28(d_half_q, amt);
                        end else begin
                            c_half_d = rotl28(c_half_q, amt);
                            d_half_d = rotl28(d_half_q, amt);
                        end
                        idx_d       = idx_q + 4'd1;
                        load_subkey = 1'b1;
                    end
                end
            end
        endcase
    end

    // Subkey is registered from the next C/D so it is valid the cycle after load.
    des_pc2 u_pc2 (
        .cd_i     ({c_half_d, d_half_d}),
        .subkey_o (pc2_out)
    );

    assign subkey_d = load_subkey ? pc2_out : subkey_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            c_half_q <= '0;
            d_half_q <= '0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= 4'd0;
            done_q   <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_half_q <= c_half_d;
            d_half_q <= d_half_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            dec_q    <= dec_d;
        end
    end

    assign bus.subkey       = subkey_q;
    assign bus.subkey_valid = valid_q;
    assign bus.round_idx    = idx_q;
    assign bus.busy         = (state_q == StIssue);
    assign bus.done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule: scoreboard bench for des_key_schedule.
// Expected subkeys come from a DES-bit-level model using cumulative rotation.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

    localparam int NUM_ROUNDS = 16;
    localparam logic [63:0] KnownKey = 64'h133457799BBCDFF1;
    localparam logic [47:0] KnownK1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KnownK2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] KnownK16 = 48'hCB3D8B0E17F5;

    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_key_schedule_if bus ();

    des_key_schedule #(.NUM_ROUNDS(NUM_ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [47:0] k;
        logic [3:0]  idx;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        done_exp = 1'b0;
    int          done_cnt = 0;
    int          acc_cnt = 0;
    logic [47:0] last_acc = '0;
    int          ready_mode = 0;
    int          rcnt = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rule_shift(int i);
        return (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
    endfunction

    // Encrypt-order subkey rnd (0..15): PC-2 of C0/D0 rotated by the running shift total.
    function automatic logic [47:0] ref_subkey(logic [63:0] k, int rnd);
        int          tot;
        logic        c [28];
        logic        d [28];
        logic        cd [57];
        logic [47:0] res;
        tot = 0;
        for (int j = 0; j <= rnd; j++) tot += rule_shift(j);
        for (int j = 0; j < 28; j++) begin
            c[j] = k[64 - TB_PC1[j]];
            d[j] = k[64 - TB_PC1[28 + j]];
        end
        cd[0] = 1'b0;
        for (int p = 1; p <= 28; p++) begin
            cd[p]      = c[(p - 1 + tot) % 28];
            cd[p + 28] = d[(p - 1 + tot) % 28];
        end
        res = '0;
        for (int i = 0; i < 48; i++) res[47 - i] = cd[TB_PC2[i]];
        return res;
    endfunction

    task automatic push_schedule(logic [63:0] k, logic dec);
        exp_t e;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            e.k   = dec ? ref_subkey(k, NUM_ROUNDS - 1 - i) : ref_subkey(k, i);
            e.idx = 4'(i);
            sb.push_back(e);
        end
    endtask

    // Monitor: compares every presented subkey with the queue head, pops on accept.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.done || done_exp) check("done_pulse", 64'(bus.done), 64'(done_exp));
                if (bus.done) done_cnt++;
                done_exp = 1'b0;
                if (bus.subkey_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_subkey: got %h with nothing expected", bus.subkey);
                    end else begin
                        check("subkey", 64'(bus.subkey), 64'(sb[0].k));
                        check("round_idx", 64'(bus.round_idx), 64'(sb[0].idx));
                        if (bus.subkey_ready) begin
                            last_acc = bus.subkey;
                            acc_cnt++;
                            if (sb[0].idx == 4'd15) done_exp = 1'b1;
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Ready driver: 0 = always, 1 = repeating 1,0,0,1, otherwise random.
    initial begin
        bus.subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.subkey_ready = 1'b1;
                1: begin
                    bus.subkey_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                    rcnt++;
                end
                default: bus.subkey_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sched(logic [63:0] k, logic dec);
        check("busy_before_start", 64'(bus.busy), 64'd0);
        bus.key     = k;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        push_schedule(k, dec);
        tick();
        bus.start   = 1'b0;
        bus.key     = {$urandom, $urandom};
        bus.decrypt = 1'($urandom_range(0, 1));
        check("valid_latency", 64'(bus.subkey_valid), 64'd1);
        check("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done();
        int d0;
        int a0;
        int n;
        d0 = done_cnt;
        a0 = acc_cnt - (NUM_ROUNDS - sb.size());
        n  = 0;
        while (done_cnt == d0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("accepted_count", 64'(acc_cnt - a0), 64'(NUM_ROUNDS));
        check("busy_after_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic wait_idx(int target);
        int n;
        n = 0;
        while (int'(bus.round_idx) != target && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idx_timeout: round_idx %0d never reached %0d", bus.round_idx, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k;
        int          d0;
        int          n;
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.key     = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        check("rst_subkey", 64'(bus.subkey), 64'd0);
        check("rst_valid", 64'(bus.subkey_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_idx", 64'(bus.round_idx), 64'd0);

        // Known vector, encrypt, ready held high.
        start_sched(KnownKey, 1'b0);
        check("enc_k1", 64'(bus.subkey), 64'(KnownK1));
        tick();
        check("enc_k2", 64'(bus.subkey), 64'(KnownK2));
        check("enc_k2_idx", 64'(bus.round_idx), 64'd1);
        wait_done();
        check("enc_k16", 64'(last_acc), 64'(KnownK16));

        // Known vector, decrypt.
        start_sched(KnownKey, 1'b1);
        check("dec_first", 64'(bus.subkey), 64'(KnownK16));
        wait_done();
        check("dec_last", 64'(last_acc), 64'(KnownK1));

        // Backpressure with ready pattern 1,0,0,1.
        ready_mode = 1;
        rcnt = 0;
        start_sched({$urandom, $urandom}, 1'b0);
        wait_done();
        ready_mode = 0;

        // Start while busy is ignored; sequence continues with the original key.
        start_sched({$urandom, $urandom}, 1'b0);
        wait_idx(5);
        bus.key     = {$urandom, $urandom};
        bus.decrypt = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        wait_done();

        // Start in the done cycle is honoured.
        d0 = done_cnt;
        start_sched({$urandom, $urandom}, 1'b1);
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", 64'(bus.done), 64'd1);
        start_sched({$urandom, $urandom}, 1'b0);
        wait_done();
        check("done_count", 64'(done_cnt - d0), 64'd2);

        // Random keys, modes and backpressure.
        ready_mode = 2;
        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom};
            start_sched(k, 1'($urandom_range(0, 1)));
            wait_done();
        end
        ready_mode = 0;
        tick();

        // Reset mid-schedule.
        start_sched({$urandom, $urandom}, 1'b0);
        wait_idx(7);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_subkey", 64'(bus.subkey), 64'd0);
        check("midrst_valid", 64'(bus.subkey_valid), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_idx", 64'(bus.round_idx), 64'd0);
        sb.delete();
        done_exp = 1'b0;
        d0 = done_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("no_partial_done", 64'(done_cnt - d0), 64'd0);
        start_sched(KnownKey, 1'b0);
        check("post_rst_k1", 64'(bus.subkey), 64'(KnownK1));
        wait_done();

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES key scheduler that produces the 48-bit round subkeys consumed by the round datapath. The datapath XORs each subkey with the expanded R half and feeds the result to SBoxArray. The block supports both encrypt order (K1..K16) and decrypt order (K16..K1) from a single 64-bit key. It delivers one subkey per accepted handshake through a valid/ready interface.

Parameters:
- NUM_ROUNDS, 16, number of subkeys issued per key; fixed by DES, exposed only for bench readability.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load key and begin schedule; sampled only when busy=0
- decrypt  input  1  sampled with start; 0 = K1..K16 order, 1 = K16..K1 order
- key  input  64  DES key, bit 63 = DES bit 1; parity bits ignored
- subkey  output  48  current round subkey, bit 47 = DES bit 1
- subkey_valid  output  1  subkey holds a valid round key
- subkey_ready  input  1  consumer accepts subkey when valid && ready
- round_idx  output  4  index of the subkey in issue order, 0..15
- busy  output  1  schedule in progress; start is ignored while high
- done  output  1  one-cycle pulse after the 16th subkey is accepted

Behaviour:
- Reset: asynchronous, active-low. Clk and rst_n are one clock and its asynchronous active-low reset. All outputs go to 0 and C/D go to 0.
- State machine: IDLE and ISSUE.
- IDLE -> ISSUE on start:
  - Latch C0/D0 = PC-1(key), each 28 bits.
  - Encrypt: C,D <= left-rotate-1 of C0,D0.
  - Decrypt: C,D <= C0,D0 unrotated. Total rotation over 16 rounds is 28, so this yields K16.
  - subkey <= PC-2(C,D) next value; subkey_valid=1, round_idx=0, busy=1.
- Latency: start at edge N gives a valid subkey after edge N+1.
- Handshake: subkey, round_idx and subkey_valid stay stable while valid && !ready.
- Accept at round_idx r<15:
  - Rotate C,D for the next round and register the new subkey on the same edge.
  - round_idx <= r+1; valid stays 1, so back-to-back issue at 1 subkey/cycle is possible.
- Shift schedule:
  - Encrypt issue index i (0..15) uses left shift of 1 for i in {0,1,8,15}, else 2.
  - Decrypt index i uses right shift: 0 for i=0, 1 for i in {1,8,15}, else 2.
- Accept at round_idx=15: valid<=0, busy<=0, done<=1 for one cycle, then return to IDLE. subkey holds its last value.
- start and done in the same cycle: start is honoured, because busy is already 0 in that cycle.
- start while busy: ignored. decrypt and key changes while busy have no effect.
- Reset mid-schedule: immediate return to IDLE with all outputs 0. No partial done.
- All rotations are modulo 28 within each half. No width growth.

Decomposition:
- Package des_pkg holds:
  - PC1 table (56 entries)
  - PC2 table (48 entries)
  - encrypt shift table SHIFTS[16]
  - localparams KEY_W=64, HALF_W=28, SUBKEY_W=48
- One sub-module, des_pc2, is natural: purely combinational 56->48 permutation, reused by the round datapath bench.
- Rotation and PC-1 stay inline.

Test Plan:
- Reset release, no start -> subkey=0, subkey_valid=0, busy=0, done=0.
- Encrypt, key=0x133457799BBCDFF1, ready held 1 -> cycle after start: subkey=0x1B02EFFC7072 (idx 0). Next cycle: 0x79AED9DBC9E5 (idx 1). Idx 15: 0xCB3D8B0E17F5. done pulses exactly once, 16 cycles after the first valid.
- Decrypt, same key, ready=1 -> idx 0 = 0xCB3D8B0E17F5, idx 15 = 0x1B02EFFC7072. The full 16-word sequence equals the encrypt sequence reversed.
- Backpressure: encrypt, ready toggles 1,0,0,1 -> subkey and round_idx hold during the ready=0 cycles. No subkey is skipped or duplicated, and the total accepted count is 16.
- start pulsed at idx 5 with a different key -> ignored; the sequence continues with the original key. start asserted in the done cycle -> new schedule starts, first subkey on the next cycle.
- rst_n asserted at idx 7 -> all outputs 0 asynchronously, no done pulse. A fresh start afterwards yields 0x1B02EFFC7072 at idx 0.
